// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: drives the ap_ctrl_hs/ap_ctrl_chain handshake of one HLS core for
// a programmed number of transactions. It bounds outstanding work with a start-timestamp
// FIFO, applies done-side backpressure through ap_continue and tracks min/max latency.
module ap_ctrl_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   parameter int CYC_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_start,
   input  logic [CNT_W-1:0] cfg_num_txn,
   input  logic             cont_hold,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             finish,
   output logic [CNT_W-1:0] started_cnt,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CYC_W-1:0] lat_max,
   output logic [CYC_W-1:0] lat_min,
   output logic             err_unexp_done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] num_txn;
   logic [CNT_W-1:0] num_nxt;
   logic [CNT_W-1:0] started_nxt;
   logic [CYC_W-1:0] cyc_cnt;
   logic [CYC_W-1:0] stamp_mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [PTR_W:0]   fill;
   logic [PTR_W:0]   fill_nxt;
   logic             run_start;
   logic             push;
   logic             consume;
   logic             pop;
   logic             fifo_empty;
   logic             start_nxt;
   logic [CYC_W-1:0] latency;

   // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
   assign fill       = wr_ptr - rd_ptr;
   assign fifo_empty = (fill == '0);
   assign run_start  = (state == IDLE) && cfg_start;
   assign push       = (state == ISSUE) && ap_start && ap_ready;
   assign consume    = ap_done && ap_continue;
   // Emptiness is judged before this cycle's push: a start cannot complete in the same cycle.
   assign pop        = consume && !fifo_empty;
   assign latency    = cyc_cnt - stamp_mem[rd_ptr[PTR_W-1:0]];

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode, handshake outputs and the look-ahead used to register ap_start.
   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      finish      = 1'b0;
      ap_continue = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_start) state_nxt = (cfg_num_txn == '0) ? FIN : ISSUE;
         end
         ISSUE: begin
            busy        = 1'b1;
            ap_continue = ap_done && !cont_hold;
            if (started_cnt == num_txn) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy        = 1'b1;
            ap_continue = ap_done && !cont_hold;
            if (done_cnt == num_txn) state_nxt = FIN;
         end
         FIN: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      num_nxt     = run_start ? cfg_num_txn : num_txn;
      started_nxt = run_start ? '0 : started_cnt + CNT_W'(push);
      fill_nxt    = fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      // ap_start is a flop: it reflects post-edge counts, so fullness before a pop keeps it low
      // for that cycle and a pop re-enables it on the following one.
      start_nxt   = (state_nxt == ISSUE) && (started_nxt < num_nxt) && (fill_nxt < DEPTH_L);
   end

   // Run bookkeeping: counts, cycle counter, FIFO pointers, latency extremes and error flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ap_start       <= 1'b0;
         num_txn        <= '0;
         started_cnt    <= '0;
         done_cnt       <= '0;
         cyc_cnt        <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         lat_max        <= '0;
         lat_min        <= '1;
         err_unexp_done <= 1'b0;
      end else begin
         ap_start    <= start_nxt;
         num_txn     <= num_nxt;
         started_cnt <= started_nxt;
         if (run_start) begin
            done_cnt       <= '0;
            cyc_cnt        <= '0;
            lat_max        <= '0;
            lat_min        <= '1;
            err_unexp_done <= 1'b0;
         end else begin
            if (busy) cyc_cnt <= cyc_cnt + CYC_W'(1);
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop) begin
               rd_ptr   <= rd_ptr + (PTR_W+1)'(1);
               done_cnt <= done_cnt + CNT_W'(1);
               if (latency > lat_max) lat_max <= latency;
               if (latency < lat_min) lat_min <= latency;
            end
            if (consume && fifo_empty) err_unexp_done <= 1'b1;
         end
      end
   end

   // Start-timestamp storage; contents are only meaningful between the pointers.
   always_ff @(posedge clock) begin
      if (push) stamp_mem[wr_ptr[PTR_W-1:0]] <= cyc_cnt;
   end

endmodule
